// File: rtl/sar_logic.sv
// Successive-approximation controller: sample phase, then one MSB-first decision per clock.
// Latency start->valid is SAMPLE_CYCLES+NBITS cycles; start is not queued and stop aborts to IDLE.
module sar_logic #(
   parameter int NBITS         = 8,
   parameter int SAMPLE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             comp_out,
   output logic             sample,
   output logic             comp_en,
   output logic [NBITS-1:0] dac_code,
   output logic [NBITS-1:0] dout,
   output logic             valid,
   output logic             busy
);

   localparam int IW = $clog2(NBITS);
   localparam logic [NBITS-1:0] MSB_ONLY = {1'b1, {(NBITS-1){1'b0}}};
   localparam logic [3:0]       CNT_LAST = 4'(SAMPLE_CYCLES - 1);
   localparam logic [IW-1:0]    IDX_TOP  = IW'(NBITS - 1);

   typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_CONVERT, S_DONE} state_t;

   state_t           state;
   logic [3:0]       cnt;
   logic [IW-1:0]    bit_idx;
   logic [NBITS-1:0] trial;

   // Current decision folded into the code, plus the next trial bit when one remains.
   always_comb begin
      trial          = dac_code;
      trial[bit_idx] = comp_out;
      if (bit_idx != '0)
         trial[bit_idx - IW'(1)] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         sample   <= 1'b0;
         comp_en  <= 1'b0;
         dac_code <= '0;
         dout     <= '0;
         valid    <= 1'b0;
         busy     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start && !stop) begin
                  state  <= S_SAMPLE;
                  cnt    <= '0;
                  sample <= 1'b1;
                  busy   <= 1'b1;
               end
            end
            S_SAMPLE: begin
               if (stop) begin
                  state    <= S_IDLE;
                  sample   <= 1'b0;
                  comp_en  <= 1'b0;
                  busy     <= 1'b0;
                  dac_code <= '0;
               end else if (cnt == CNT_LAST) begin
                  state    <= S_CONVERT;
                  sample   <= 1'b0;
                  comp_en  <= 1'b1;
                  dac_code <= MSB_ONLY;
                  bit_idx  <= IDX_TOP;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            S_CONVERT: begin
               if (stop) begin
                  state    <= S_IDLE;
                  comp_en  <= 1'b0;
                  busy     <= 1'b0;
                  dac_code <= '0;
               end else begin
                  dac_code <= trial;
                  if (bit_idx == '0) begin
                     state   <= S_DONE;
                     dout    <= trial;
                     valid   <= 1'b1;
                     comp_en <= 1'b0;
                     busy    <= 1'b0;
                  end else begin
                     bit_idx <= bit_idx - IW'(1);
                  end
               end
            end
            S_DONE: begin
               valid    <= 1'b0;
               dac_code <= '0;
               if (start) begin
                  state  <= S_SAMPLE;
                  cnt    <= '0;
                  sample <= 1'b1;
                  busy   <= 1'b1;
               end else begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sar_logic.sv
// Directed bench for sar_logic at default parameters; comparator modelled as vin >= dac_code.
module tb_sar_logic;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       stop;
   logic       comp_out;
   logic       sample;
   logic       comp_en;
   logic [7:0] dac_code;
   logic [7:0] dout;
   logic       valid;
   logic       busy;
   logic [7:0] vin;

   int tests_run;
   int tests_failed;

   sar_logic #(.NBITS(8), .SAMPLE_CYCLES(2)) dut (
      .clk      (clk),
      .rst      (rst_n),
      .start    (start),
      .stop     (stop),
      .comp_out (comp_out),
      .sample   (sample),
      .comp_en  (comp_en),
      .dac_code (dac_code),
      .dout     (dout),
      .valid    (valid),
      .busy     (busy)
   );

   assign comp_out = (vin >= dac_code);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag, input bit dout_too);
      check({tag, " sample"}, 32'(sample), 32'd0);
      check({tag, " comp_en"}, 32'(comp_en), 32'd0);
      check({tag, " busy"}, 32'(busy), 32'd0);
      check({tag, " valid"}, 32'(valid), 32'd0);
      check({tag, " dac_code"}, 32'(dac_code), 32'd0);
      if (dout_too) check({tag, " dout"}, 32'(dout), 32'd0);
   endtask

   // One conversion from IDLE; observation n is taken after edge E0+n.
   task automatic run_conv(input string tag, input logic [7:0] v, input logic [7:0] exp,
                           input bit poke, input bit chk_seq);
      logic [7:0] codes [8];
      logic [7:0] seq [8];
      int sc, cc, vc, vn, both;
      logic [7:0] got;
      seq = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A, 8'h5B};
      sc = 0; cc = 0; vc = 0; vn = -1; both = 0; got = 8'h00;
      vin   = v;
      start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, " busy after E0"}, 32'(busy), 32'd1);
      for (int n = 0; n < 25; n++) begin
         start = poke && (n == 1 || n == 5);
         if (sample) sc++;
         if (comp_en) begin
            if (cc < 8) codes[cc] = dac_code;
            cc++;
         end
         if (sample && comp_en) both++;
         if (valid) begin
            vc++;
            vn  = n;
            got = dout;
            check({tag, " busy in DONE"}, 32'(busy), 32'd0);
         end
         tick();
      end
      start = 1'b0;
      check({tag, " valid count"}, 32'(vc), 32'd1);
      check({tag, " valid edge"}, 32'(vn), 32'd10);
      check({tag, " dout"}, 32'(got), 32'(exp));
      check({tag, " sample cycles"}, 32'(sc), 32'd2);
      check({tag, " comp_en cycles"}, 32'(cc), 32'd8);
      check({tag, " sample&comp_en overlap"}, 32'(both), 32'd0);
      if (chk_seq)
         for (int k = 0; k < 8; k++)
            check($sformatf("%s dac_code[%0d]", tag, k), 32'(codes[k]), 32'(seq[k]));
   endtask

   initial begin
      int vcnt;
      int last_n;
      tests_run = 0; tests_failed = 0;
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; vin = 8'h00;
      #12;
      check_all_zero("reset", 1'b1);
      rst_n = 1'b1;
      tick();
      tick();
      check_all_zero("idle", 1'b1);

      run_conv("conv5A", 8'h5A, 8'h5A, 1'b0, 1'b1);
      run_conv("vinFF", 8'hFF, 8'hFF, 1'b0, 1'b0);
      run_conv("vin00", 8'h00, 8'h00, 1'b0, 1'b0);
      run_conv("vin80", 8'h80, 8'h80, 1'b0, 1'b0);

      // Back-to-back with start held
      vin = 8'h33; start = 1'b1; vcnt = 0; last_n = -1;
      tick();
      for (int n = 0; n < 60 && vcnt < 4; n++) begin
         if (valid) begin
            check($sformatf("b2b dout %0d", vcnt), 32'(dout), (vcnt % 2 == 0) ? 32'h33 : 32'hCC);
            check($sformatf("b2b edge %0d", vcnt), 32'(n), 32'(10 + 11 * vcnt));
            vcnt++;
            vin = (vin == 8'h33) ? 8'hCC : 8'h33;
            if (vcnt == 4) start = 1'b0;
         end
         tick();
      end
      start = 1'b0;
      check("b2b valid count", 32'(vcnt), 32'd4);
      tick();
      tick();

      // Abort in the 4th CONVERT cycle
      run_conv("pre-abort", 8'h5A, 8'h5A, 1'b0, 1'b0);
      vin = 8'h11; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      check("abort comp_en before stop", 32'(comp_en), 32'd1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check_all_zero("abort", 1'b0);
      check("abort dout kept", 32'(dout), 32'h5A);
      vcnt = 0;
      for (int n = 0; n < 15; n++) begin
         if (valid) vcnt++;
         tick();
      end
      check("abort no valid", 32'(vcnt), 32'd0);
      check("abort dout still", 32'(dout), 32'h5A);
      run_conv("post-abort", 8'h33, 8'h33, 1'b0, 1'b0);

      // Async reset mid-SAMPLE
      start = 1'b1;
      tick();
      start = 1'b0;
      check("pre-rst sample", 32'(sample), 32'd1);
      #2 rst_n = 1'b0;
      #1 check_all_zero("rst mid-sample", 1'b1);
      #1 rst_n = 1'b1;
      tick();
      run_conv("after rst1", 8'hA5, 8'hA5, 1'b0, 1'b0);

      // Async reset mid-CONVERT
      vin = 8'h77; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      check("pre-rst comp_en", 32'(comp_en), 32'd1);
      #2 rst_n = 1'b0;
      #1 check_all_zero("rst mid-convert", 1'b1);
      #1 rst_n = 1'b1;
      tick();
      run_conv("after rst2", 8'h3C, 8'h3C, 1'b0, 1'b0);

      // start pulses during SAMPLE and CONVERT are ignored
      run_conv("ignore start", 8'h96, 8'h96, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/sar_logic.md
# sar_logic

Synchronous successive-approximation controller for the SAR-ADC model. On each conversion request it runs a sample phase, then a binary search: one comparator decision per clock, MSB first. It drives the comparator clock enable (`clk_en` of the ideal clock generator), the track/hold switch and the capacitive-DAC code. When the search finishes it presents the converted word with a one-cycle valid strobe.

## Interface

Parameters:
- `NBITS`, 8: resolution in bits; legal range 2..16.
- `SAMPLE_CYCLES`, 2: number of clock cycles `sample` is held high; legal range 1..15.

Ports:
- `clk` input 1: conversion clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: conversion request; sampled only in IDLE and DONE.
- `stop` input 1: synchronous abort; highest priority after reset.
- `comp_out` input 1: comparator decision; 1 means vin >= DAC voltage.
- `sample` output 1: track switch closed (input tracking).
- `comp_en` output 1: comparator clock enable, feeds the clock generator `clk_en`.
- `dac_code` output NBITS: present trial code to the capacitive DAC.
- `dout` output NBITS: last completed conversion result.
- `valid` output 1: one-cycle strobe marking a new `dout`.
- `busy` output 1: high in SAMPLE and CONVERT.

## Operation

- All outputs are registered or decoded from state registers only. There is no combinational path from any input to any output.
- Reset (`rst`=0): state=IDLE. All outputs read 0: `sample`, `comp_en`, `valid`, `busy`, `dac_code`=0 and `dout`=0.
- States and transitions:
  - IDLE: `start`=1 moves to SAMPLE; otherwise stay.
  - SAMPLE: a counter runs from 0 to SAMPLE_CYCLES-1. On the last count, move to CONVERT, load `dac_code`=1<<(NBITS-1) and set bit index i=NBITS-1.
  - CONVERT: each cycle, register `comp_out` into bit i of the result.
    - `comp_out`=1 keeps bit i of `dac_code`; `comp_out`=0 clears it.
    - If i>0, set bit i-1 of `dac_code` and decrement i.
    - If i=0, move to DONE.
  - DONE: `dout` <= final code; `valid`=1 for exactly this cycle. Then go to SAMPLE if `start`=1, else IDLE.
- `start` is ignored in SAMPLE and CONVERT; there is no queuing.
- `stop`=1 in SAMPLE or CONVERT forces IDLE on the next edge:
  - `sample` and `comp_en` go to 0 and `dac_code` goes to 0.
  - `dout` is unchanged and no `valid` pulse is issued.
- `stop` in IDLE or DONE is ignored, so a DONE cycle still completes and strobes `valid`.
- Simultaneous `stop` and `start` in IDLE: `stop` wins and the block stays in IDLE.
- `dout` holds its value until the next DONE.
- `dac_code` holds the final code through DONE and clears to 0 on entry to IDLE.
- Result bits are fixed once decided; bits below i read 0 except the trial bit.
- Counter widths: sample counter 4 bits; bit index ceil(log2(NBITS)) bits. Neither counter wraps; each is reloaded on every state entry.

## Timing

- Let edge E0 be the rising edge at which `start`=1 is seen in IDLE.
- After E0: `sample`=1, `busy`=1.
- After E0+SAMPLE_CYCLES: `sample`=0, `comp_en`=1, `dac_code`=MSB-only.
- Edge E0+SAMPLE_CYCLES+j (j=1..NBITS) samples `comp_out` for bit NBITS-j. The bench must settle `comp_out` before that edge.
- After E0+SAMPLE_CYCLES+NBITS: state=DONE, `comp_en`=0, `busy`=0, `valid`=1, `dout` valid.
- Latency from the `start` edge to the `valid` edge is SAMPLE_CYCLES+NBITS cycles. Throughput with `start` held high is one conversion per SAMPLE_CYCLES+NBITS+1 cycles (11 at defaults).
- `sample` and `comp_en` are never high in the same cycle.
- Asynchronous reset mid-conversion clears all outputs immediately, without waiting for an edge. Operation resumes with IDLE on the first edge after `rst` deasserts.

## Test plan

- Defaults; comparator model `comp_out` = (0x5A >= `dac_code`); one `start` pulse. Required response:
  - `dac_code` sequence 80,40,60,50,58,5C,5A,5B.
  - `dout`=0x5A with `valid` exactly 10 edges after E0.
  - `sample` high 2 cycles, `comp_en` high 8 cycles.
- Extremes: vin=0xFF gives `dout`=0xFF; vin=0x00 gives `dout`=0x00; vin=0x80 gives 0x80. Each has exactly one `valid` pulse.
- Back-to-back: `start` held high with vin alternating 0x33 and 0xCC per conversion. Required: `valid` every 11 cycles, with `dout` alternating 0x33/0xCC and no gap state.
- Abort: `stop` pulsed during the 4th CONVERT cycle while `dout`=0x5A from a prior run. Required:
  - IDLE next edge, all of `dac_code`/`comp_en`/`busy` at 0.
  - No `valid`; `dout` stays 0x5A.
  - The next `start` converts normally.
- `rst` dropped asynchronously mid-SAMPLE and mid-CONVERT. Required: all outputs go 0 before the next edge and `dout`=0. A `start` after release yields a correct conversion.
- `start` pulses during SAMPLE and during CONVERT are ignored: exactly one `valid`, with timing unchanged.
